// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack-operation sequencer and the SP register block.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_PUSH      = 3'd0,
    OP_POP       = 3'd1,
    OP_CALL      = 3'd2,
    OP_RET       = 3'd3,
    OP_LD_SP_IMM = 3'd4,
    OP_ADD_SP_E  = 3'd5
  } op_e;

  localparam logic [2:0] SP_SEL_SP           = 3'd0;
  localparam logic [2:0] SP_SEL_INCR         = 3'd1;
  localparam logic [2:0] SP_SEL_DECR         = 3'd2;
  localparam logic [2:0] SP_SEL_DATA_BUS     = 3'd3;
  localparam logic [2:0] SP_SEL_DATA_BUS_REL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INT,
    ST_WR_HI,
    ST_WR_LO,
    ST_RD_LO,
    ST_RD_HI,
    ST_IMM_LO,
    ST_IMM_HI
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/stack_step_timer.sv
// Counts the clocks of one bus step and flags the step's last clock.
module stack_step_timer #(
  parameter int MEM_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic step_last
);

  localparam int CW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // States only change on step_last, so wrapping here restarts the count on entry.
  always_ff @(posedge clock) begin
    if (reset || !run || step_last) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  assign step_last = run && (cnt == CW'(MEM_CYCLES - 1));

endmodule

// File: rtl/stack_seq.sv
// Sequences PUSH/POP/CALL/RET/LD SP,nn/ADD SP,e into bus steps and SP-block controls.
// Every action fires only on a step's last clock; popped bytes assemble into pop_data.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int MEM_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] push_data,
  input  logic [7:0]  mem_rdata,
  input  logic [15:0] sp,
  output logic        busy,
  output logic        done,
  output logic [2:0]  sp_sel,
  output logic        write_temp_buf,
  output logic        mem_addr_is_sp,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        pc_incr,
  output logic        load_pc,
  output logic [15:0] pop_data
);

  state_e      state, state_nx;
  op_e         op_q;
  logic [15:0] data_q;
  logic        step_last, act, accept, done_nx, latch_lo, latch_hi;

  // The SP block owns all address arithmetic; sp is only passed through it.
  logic unused_sp;
  assign unused_sp = ^sp;

  stack_step_timer #(.MEM_CYCLES(MEM_CYCLES)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .run       (state != ST_IDLE),
    .step_last (step_last)
  );

  assign accept = (state == ST_IDLE) && start && op_is_legal(op);
  assign act    = step_last && !reset;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_PUSH;
      data_q   <= 16'h0000;
      pop_data <= 16'h0000;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (accept) begin
        op_q   <= op_e'(op);
        data_q <= push_data;
      end
      if (latch_lo) pop_data[7:0]  <= mem_rdata;
      if (latch_hi) pop_data[15:8] <= mem_rdata;
    end
  end

  always_comb begin
    state_nx       = state;
    done_nx        = 1'b0;
    sp_sel         = SP_SEL_SP;
    write_temp_buf = 1'b0;
    mem_addr_is_sp = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_wdata      = 8'h00;
    pc_incr        = 1'b0;
    load_pc        = 1'b0;
    latch_lo       = 1'b0;
    latch_hi       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(op))
            OP_PUSH, OP_CALL: state_nx = ST_INT;
            OP_POP, OP_RET:   state_nx = ST_RD_LO;
            default:          state_nx = ST_IMM_LO;
          endcase
        end
      end
      // INT opens PUSH/CALL, closes RET, and pads ADD SP,e.
      ST_INT: begin
        if (act) begin
          case (op_q)
            OP_PUSH, OP_CALL: begin
              sp_sel   = SP_SEL_DECR;
              state_nx = ST_WR_HI;
            end
            OP_RET: begin
              load_pc  = 1'b1;
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
            end
            default: begin
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
            end
          endcase
        end
      end
      ST_WR_HI: begin
        mem_addr_is_sp = 1'b1;
        mem_wdata      = data_q[15:8];
        if (act) begin
          mem_wr   = 1'b1;
          sp_sel   = SP_SEL_DECR;
          state_nx = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        mem_addr_is_sp = 1'b1;
        mem_wdata      = data_q[7:0];
        if (act) begin
          mem_wr   = 1'b1;
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      ST_RD_LO: begin
        mem_addr_is_sp = 1'b1;
        if (act) begin
          mem_rd   = 1'b1;
          latch_lo = 1'b1;
          sp_sel   = SP_SEL_INCR;
          state_nx = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        mem_addr_is_sp = 1'b1;
        if (act) begin
          mem_rd   = 1'b1;
          latch_hi = 1'b1;
          sp_sel   = SP_SEL_INCR;
          if (op_q == OP_RET) begin
            state_nx = ST_INT;
          end else begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      ST_IMM_LO: begin
        if (act) begin
          mem_rd  = 1'b1;
          pc_incr = 1'b1;
          if (op_q == OP_LD_SP_IMM) begin
            write_temp_buf = 1'b1;
            state_nx       = ST_IMM_HI;
          end else begin
            sp_sel   = SP_SEL_DATA_BUS_REL;
            state_nx = ST_INT;
          end
        end
      end
      ST_IMM_HI: begin
        if (act) begin
          mem_rd   = 1'b1;
          pc_incr  = 1'b1;
          sp_sel   = SP_SEL_DATA_BUS;
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
